writeback_stage: RTL and testbench

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 148 ++++++++++++++
 tb/tb_writeback_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: a registered write port with a one-entry skid buffer in front of it.
// Optional feature macro: WB_LOAD_EXT_EN. When defined, load data is lane-extracted and extended.
// When undefined, mem_rdata passes through unchanged.
module writeback_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic [DATA_W-1:0] link_addr,
  input  logic [1:0]        res_sel,
  input  logic              reg_write,
  input  logic [REG_AW-1:0] write_reg,
  input  logic [1:0]        load_size,
  input  logic [1:0]        byte_off,
  input  logic              load_signed,
  input  logic              wb_stall,
  input  logic              flush,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [15:0]       retire_count
);

  logic [DATA_W-1:0] memData;
  logic [DATA_W-1:0] inData;
  logic              handshake;

  logic              outValid;
  logic              outRegWrite;
  logic [REG_AW-1:0] outAddr;
  logic [DATA_W-1:0] outData;

  logic              skidValid;
  logic              skidRegWrite;
  logic [REG_AW-1:0] skidAddr;
  logic [DATA_W-1:0] skidData;

`ifdef WB_LOAD_EXT_EN
  logic [31:0] memWord;
  logic [7:0]  memByte;
  logic [15:0] memHalf;

  // Pick the addressed byte/halfword lane and extend it to the full data width.
  always_comb begin
    memWord = mem_rdata[31:0];
    memByte = memWord[8*byte_off +: 8];
    memHalf = memWord[16*byte_off[1] +: 16];
    case (load_size)
      2'd0: begin
        if (load_signed) memData = DATA_W'($signed(memByte));
        else             memData = DATA_W'(memByte);
      end
      2'd1: begin
        if (load_signed) memData = DATA_W'($signed(memHalf));
        else             memData = DATA_W'(memHalf);
      end
      default: begin
        if (load_signed) memData = DATA_W'($signed(memWord));
        else             memData = DATA_W'(memWord);
      end
    endcase
  end
`else
  logic unusedLoadCtl;

  // Without extraction the load controls have no effect.
  always_comb begin
    memData       = mem_rdata;
    unusedLoadCtl = ^{load_size, byte_off, load_signed};
  end
`endif

  // Result source select; the reserved code produces zero so nothing stale leaks out.
  always_comb begin
    case (res_sel)
      2'd0:    inData = alu_result;
      2'd1:    inData = memData;
      2'd2:    inData = link_addr;
      default: inData = '0;
    endcase
  end

  assign in_ready  = ~skidValid;
  assign handshake = in_valid & in_ready;

  // Output register: holds under stall, otherwise drains the skid first, then takes new input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outValid    <= 1'b0;
      outRegWrite <= 1'b0;
      outAddr     <= '0;
      outData     <= '0;
    end else if (flush) begin
      outValid <= 1'b0;
    end else if (!wb_stall) begin
      if (skidValid) begin
        outValid    <= 1'b1;
        outRegWrite <= skidRegWrite;
        outAddr     <= skidAddr;
        outData     <= skidData;
      end else if (handshake) begin
        outValid    <= 1'b1;
        outRegWrite <= reg_write;
        outAddr     <= write_reg;
        outData     <= inData;
      end else begin
        outValid <= 1'b0;
      end
    end
  end

  // Skid register: catches a handshake that the output register cannot take this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skidValid    <= 1'b0;
      skidRegWrite <= 1'b0;
      skidAddr     <= '0;
      skidData     <= '0;
    end else if (flush) begin
      skidValid <= 1'b0;
    end else if (wb_stall || skidValid) begin
      // Under stall the skid fills; while draining it refills only if a handshake coincides.
      if (!wb_stall) skidValid <= handshake;
      else if (handshake) skidValid <= 1'b1;
      if (handshake) begin
        skidRegWrite <= reg_write;
        skidAddr     <= write_reg;
        skidData     <= inData;
      end
    end
  end

  assign rf_we    = outValid & outRegWrite & (outAddr != '0);
  assign rf_waddr = outAddr;
  assign rf_wdata = outData;

  // Count writes that actually leave the port; a flush does not cancel one retiring now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) retire_count <= '0;
    else if (rf_we && !wb_stall) retire_count <= retire_count + 16'd1;
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage: expected writes are queued at handshake and
// compared when the write retires from the register-file port.
module tb_writeback_stage;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] alu_result, mem_rdata, link_addr;
  logic [1:0]        res_sel;
  logic              reg_write;
  logic [REG_AW-1:0] write_reg;
  logic [1:0]        load_size, byte_off;
  logic              load_signed;
  logic              wb_stall;
  logic              flush;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [15:0]       retire_count;

  int          nChecks = 0;
  int          nFails  = 0;
  logic [36:0] sbQ[$];
  logic [36:0] sbEntry;
  logic [15:0] expCount = '0;
  logic [15:0] baseCount;

  writeback_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .link_addr(link_addr),
    .res_sel(res_sel), .reg_write(reg_write), .write_reg(write_reg),
    .load_size(load_size), .byte_off(byte_off), .load_signed(load_signed),
    .wb_stall(wb_stall), .flush(flush), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result for the bundle currently on the inputs.
  function automatic logic [31:0] expData(input logic [1:0] sel, input logic [31:0] alu,
                                          input logic [31:0] mem, input logic [31:0] link,
                                          input logic [1:0] sz, input logic [1:0] off,
                                          input logic sgn);
    logic [31:0] sh;
    logic [31:0] r;
    r = 32'h0;
    case (sel)
      2'd0: r = alu;
      2'd2: r = link;
      2'd3: r = 32'h0;
      default: begin
`ifdef WB_LOAD_EXT_EN
        if (sz == 2'd0) begin
          sh = mem >> (off * 8);
          r  = {24'h0, sh[7:0]};
          if (sgn && sh[7]) r = r | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
          sh = off[1] ? (mem >> 16) : mem;
          r  = {16'h0, sh[15:0]};
          if (sgn && sh[15]) r = r | 32'hFFFF_0000;
        end else begin
          r = mem;
        end
`else
        sh = {30'h0, sz} ^ {30'h0, off} ^ {31'h0, sgn};
        r  = mem | (sh & 32'h0);
`endif
      end
    endcase
    return r;
  endfunction

  task automatic drive(input logic v, input logic [1:0] sel, input logic [4:0] wr,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] link,
                       input logic [1:0] sz, input logic [1:0] off, input logic sgn);
    in_valid = v; res_sel = sel; write_reg = wr; reg_write = 1'b1;
    alu_result = alu; mem_rdata = mem; link_addr = link;
    load_size = sz; byte_off = off; load_signed = sgn;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  // One clock: evaluate outputs at the falling edge, update the scoreboard, step past the rising edge.
  task automatic cyc();
    @(negedge clk);
    chk("retire_count", retire_count, expCount);
    if (rf_we && !wb_stall) begin
      expCount++;
      chk("sb_nonempty", sbQ.size() != 0, 1);
      if (sbQ.size() != 0) begin
        sbEntry = sbQ.pop_front();
        chk("wb_addr", rf_waddr, sbEntry[36:32]);
        chk("wb_data", rf_wdata, sbEntry[31:0]);
      end
    end
    if (in_valid && in_ready && reg_write && write_reg != 0)
      sbQ.push_back({write_reg, expData(res_sel, alu_result, mem_rdata, link_addr,
                                        load_size, byte_off, load_signed)});
    if (flush) sbQ.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; wb_stall = 1'b0; flush = 1'b0;
    drive(1'b0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0);
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_count", retire_count, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Basic ALU write, one-cycle latency.
    drive(1'b1, 2'd0, 5'd5, 32'h1234, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0);
    cyc(); idle();
    chk("alu_rf_we", rf_we, 1);
    chk("alu_waddr", rf_waddr, 5);
    chk("alu_wdata", rf_wdata, 32'h1234);
    cyc();
    chk("alu_count", retire_count, 1);

    // Back-to-back MEM, LINK and reserved selects.
    drive(1'b1, 2'd1, 5'd6, 32'h1, 32'hA5A5_1234, 32'h2, 2'd2, 2'd0, 1'b0); cyc();
    drive(1'b1, 2'd2, 5'd7, 32'h1, 32'h3, 32'h0000_4000, 2'd0, 2'd0, 1'b0); cyc();
    drive(1'b1, 2'd3, 5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 2'd0, 1'b0); cyc();
    idle();
    chk("sel3_zero", rf_wdata, 0);
    cyc(); cyc();

`ifdef WB_LOAD_EXT_EN
    drive(1'b1, 2'd1, 5'd9, 32'h0, 32'h0080_0000, 32'h0, 2'd0, 2'd2, 1'b1); cyc(); idle();
    chk("lb_signed", rf_wdata, 32'hFFFF_FF80);
    drive(1'b1, 2'd1, 5'd9, 32'h0, 32'h0080_0000, 32'h0, 2'd0, 2'd2, 1'b0); cyc(); idle();
    chk("lb_unsigned", rf_wdata, 32'h0000_0080);
    drive(1'b1, 2'd1, 5'd10, 32'h0, 32'h8001_7FFF, 32'h0, 2'd1, 2'd3, 1'b1); cyc(); idle();
    chk("lh_hi_signed", rf_wdata, 32'hFFFF_8001);
`else
    drive(1'b1, 2'd1, 5'd9, 32'h0, 32'h0080_0000, 32'h0, 2'd0, 2'd2, 1'b1); cyc(); idle();
    chk("mem_passthru", rf_wdata, 32'h0080_0000);
`endif
    cyc(); cyc();

    // Randomised traffic with stalls; the scoreboard checks order and content.
    for (int i = 0; i < 40; i++) begin
      drive($urandom_range(0, 1), 2'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
            2'($urandom), 2'($urandom), 1'($urandom));
      reg_write = ($urandom_range(0, 3) != 0);
      wb_stall  = ($urandom_range(0, 2) == 0);
      cyc();
    end
    idle(); wb_stall = 1'b0;
    repeat (3) cyc();

    // Stall: first bundle held on the port, second in the skid, third refused.
    baseCount = retire_count;
    drive(1'b1, 2'd0, 5'd11, 32'hAAAA_0001, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0); cyc();
    wb_stall = 1'b1;
    drive(1'b1, 2'd0, 5'd12, 32'hBBBB_0002, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0); cyc();
    drive(1'b1, 2'd0, 5'd13, 32'hCCCC_0003, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      chk("stall_in_ready", in_ready, 0);
      chk("stall_hold_addr", rf_waddr, 11);
      chk("stall_hold_data", rf_wdata, 32'hAAAA_0001);
      chk("stall_hold_we", rf_we, 1);
      cyc();
    end
    idle(); wb_stall = 1'b0;
    cyc();
    chk("drain_addr", rf_waddr, 12);
    cyc();
    chk("stall_count", retire_count, baseCount + 16'd2);
    cyc();

    // Writes to register 0 are suppressed.
    baseCount = retire_count;
    drive(1'b1, 2'd0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0); cyc(); idle();
    chk("r0_rf_we", rf_we, 0);
    cyc();
    chk("r0_count", retire_count, baseCount);

    // Flush with the skid full and a new bundle offered.
    baseCount = retire_count;
    drive(1'b1, 2'd0, 5'd14, 32'h1111_0014, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0); cyc();
    wb_stall = 1'b1;
    drive(1'b1, 2'd0, 5'd15, 32'h1111_0015, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0); cyc();
    drive(1'b1, 2'd0, 5'd16, 32'h1111_0016, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0);
    flush = 1'b1; cyc();
    flush = 1'b0; idle(); wb_stall = 1'b0;
    chk("flush_rf_we", rf_we, 0);
    chk("flush_in_ready", in_ready, 1);
    repeat (4) cyc();
    chk("flush_count", retire_count, baseCount);

    // A write retiring in the flush cycle still counts.
    baseCount = retire_count;
    drive(1'b1, 2'd0, 5'd17, 32'h2222_0017, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0); cyc();
    idle(); flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush_retire_count", retire_count, baseCount + 16'd1);
    chk("flush_retire_we", rf_we, 0);

    // Asynchronous reset between edges while stalled with both entries full.
    drive(1'b1, 2'd0, 5'd18, 32'h3333_0018, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0); cyc();
    wb_stall = 1'b1;
    drive(1'b1, 2'd0, 5'd19, 32'h3333_0019, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0); cyc();
    idle();
    #1 rst = 1'b1;
    #1;
    chk("arst_rf_we", rf_we, 0);
    chk("arst_waddr", rf_waddr, 0);
    chk("arst_wdata", rf_wdata, 0);
    chk("arst_count", retire_count, 0);
    chk("arst_in_ready", in_ready, 1);
    sbQ.delete();
    expCount = '0;
    #1 rst = 1'b0;
    wb_stall = 1'b0;
    repeat (3) cyc();

    chk("sb_empty", sbQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
